// File: rtl/card_dealer.sv
// card_dealer: hands out the shuffled deck one card at a time over valid/ready.
// Runs the opening deal and start-card flip, then serves burst draws.
module card_dealer #(
   parameter int N_CARDS   = 108,
   parameter int N_PLAYERS = 4,
   parameter int HAND_SIZE = 7
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic [5:0] i_deck [N_CARDS],
   input  logic       i_deck_valid,
   input  logic       i_deal_start,
   input  logic       i_draw_req,
   input  logic [2:0] i_draw_cnt,
   input  logic [1:0] i_draw_player,
   input  logic       i_card_ready,
   output logic       o_card_valid,
   output logic [5:0] o_card,
   output logic [1:0] o_card_player,
   output logic       o_card_discard,
   output logic       o_busy,
   output logic       o_empty,
   output logic [6:0] o_remaining,
   output logic       o_underflow
);

   localparam int PW     = $clog2(N_CARDS + 1);
   localparam int IW     = $clog2(N_CARDS);
   localparam int N_DEAL = N_PLAYERS * HAND_SIZE;
   localparam int KW     = $clog2(N_DEAL);

   localparam logic [PW-1:0] PTR_END = PW'(N_CARDS);
   localparam logic [KW-1:0] K_LAST  = KW'(N_DEAL - 1);
   localparam logic [1:0]    PL_LAST = 2'(N_PLAYERS - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_DEAL,
      S_FLIP,
      S_DRAW
   } state_e;

   state_e          state_q, state_d;
   logic [PW-1:0]   ptr_q, ptr_d;
   logic [KW-1:0]   k_q, k_d;
   logic [1:0]      pl_q, pl_d;
   logic [2:0]      cnt_q, cnt_d;
   logic [1:0]      dpl_q, dpl_d;

   logic            empty;
   logic            xfer;
   logic [IW-1:0]   idx;

   assign empty = (ptr_q == PTR_END);
   assign xfer  = o_card_valid && i_card_ready;
   // Keep the deck index in range once the pointer sits past the last card.
   assign idx   = empty ? '0 : ptr_q[IW-1:0];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= S_IDLE;
         ptr_q   <= PTR_END;
         k_q     <= '0;
         pl_q    <= '0;
         cnt_q   <= '0;
         dpl_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         k_q     <= k_d;
         pl_q    <= pl_d;
         cnt_q   <= cnt_d;
         dpl_q   <= dpl_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      k_d     = k_q;
      pl_d    = pl_q;
      cnt_d   = cnt_q;
      dpl_d   = dpl_q;
      if (xfer) begin
         ptr_d = ptr_q + 1'b1;
      end
      unique case (state_q)
         S_IDLE: begin
            if (i_deck_valid) begin
               ptr_d = '0;
            end else if (i_deal_start && !empty) begin
               state_d = S_DEAL;
               k_d     = '0;
               pl_d    = '0;
            end else if (i_draw_req && (i_draw_cnt != 3'd0)) begin
               state_d = S_DRAW;
               cnt_d   = i_draw_cnt;
               dpl_d   = i_draw_player;
            end
         end
         S_DEAL: begin
            if (empty) begin
               state_d = S_IDLE;
            end else if (xfer) begin
               if (k_q == K_LAST) begin
                  state_d = S_FLIP;
               end else begin
                  k_d  = k_q + 1'b1;
                  pl_d = (pl_q == PL_LAST) ? 2'd0 : pl_q + 2'd1;
               end
            end
         end
         S_FLIP: begin
            if (empty || xfer) begin
               state_d = S_IDLE;
            end
         end
         S_DRAW: begin
            if (empty) begin
               state_d = S_IDLE;
            end else if (xfer) begin
               if (cnt_q == 3'd1) begin
                  state_d = S_IDLE;
               end else begin
                  cnt_d = cnt_q - 3'd1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      o_busy         = (state_q != S_IDLE);
      o_empty        = empty;
      o_remaining    = 7'(PTR_END - ptr_q);
      o_card_valid   = o_busy && !empty;
      o_underflow    = o_busy && empty;
      o_card         = o_card_valid ? i_deck[idx] : 6'd0;
      o_card_discard = o_card_valid && (state_q == S_FLIP);
      o_card_player  = 2'd0;
      if (o_card_valid) begin
         unique case (state_q)
            S_DEAL:  o_card_player = pl_q;
            S_DRAW:  o_card_player = dpl_q;
            default: o_card_player = 2'd0;
         endcase
      end
   end

endmodule

// File: tb/tb_card_dealer.sv
// tb_card_dealer: card_dealer against a queue-based model of the cards owed,
// plus hand-computed checks on the dealt sequence.
module tb_card_dealer;

   localparam int NC = 108;
   localparam int NP = 4;
   localparam int HS = 7;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [5:0] deck [NC];
   logic       deck_valid = 1'b0;
   logic       deal_start = 1'b0;
   logic       draw_req = 1'b0;
   logic [2:0] draw_cnt = 3'd0;
   logic [1:0] draw_pl = 2'd0;
   logic       card_ready = 1'b1;
   logic       card_valid;
   logic [5:0] card;
   logic [1:0] card_pl;
   logic       card_dc;
   logic       busy;
   logic       empty;
   logic [6:0] remaining;
   logic       underflow;

   card_dealer #(.N_CARDS(NC), .N_PLAYERS(NP), .HAND_SIZE(HS)) dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_deck        (deck),
      .i_deck_valid  (deck_valid),
      .i_deal_start  (deal_start),
      .i_draw_req    (draw_req),
      .i_draw_cnt    (draw_cnt),
      .i_draw_player (draw_pl),
      .i_card_ready  (card_ready),
      .o_card_valid  (card_valid),
      .o_card        (card),
      .o_card_player (card_pl),
      .o_card_discard(card_dc),
      .o_busy        (busy),
      .o_empty       (empty),
      .o_remaining   (remaining),
      .o_underflow   (underflow)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail = 0;

   task automatic chk(string nm, int act, int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: cards still owed (disc<<8 | player<<6 | card), pending underflow,
   // and where the pointer must be.
   int  exp_q[$];
   bit  ufp = 1'b0;
   int  mptr = NC;
   int  mp;
   int  log_card[$];
   int  log_pl[$];
   int  log_dc[$];
   int  uf_seen = 0;

   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         ufp  = 1'b0;
         mptr = NC;
      end
      chk("valid", int'(card_valid), int'(exp_q.size() > 0));
      if (exp_q.size() > 0 && card_valid) begin
         chk("card", int'(card), exp_q[0] & 63);
         chk("player", int'(card_pl), (exp_q[0] >> 6) & 3);
         chk("discard", int'(card_dc), exp_q[0] >> 8);
      end
      chk("underflow", int'(underflow), int'(exp_q.size() == 0 && ufp));
      chk("busy", int'(busy), int'(exp_q.size() > 0 || ufp));
      chk("remaining", int'(remaining), NC - mptr);
      chk("empty", int'(empty), int'(mptr == NC));
      if (underflow) uf_seen++;
      if (!rst_n) begin
      end else if (exp_q.size() > 0) begin
         if (card_ready && card_valid) begin
            log_card.push_back(int'(card));
            log_pl.push_back(int'(card_pl));
            log_dc.push_back(int'(card_dc));
            void'(exp_q.pop_front());
            mptr++;
         end
      end else if (ufp) begin
         ufp = 1'b0;
      end else if (deck_valid) begin
         mptr = 0;
      end else if (deal_start && mptr != NC) begin
         mp = mptr;
         for (int i = 0; i < NP * HS; i++) begin
            if (mp == NC) begin
               ufp = 1'b1;
               break;
            end
            exp_q.push_back(((i % NP) << 6) | int'(deck[mp]));
            mp++;
         end
         if (!ufp) begin
            if (mp == NC) ufp = 1'b1;
            else exp_q.push_back((1 << 8) | int'(deck[mp]));
         end
      end else if (draw_req && draw_cnt != 3'd0) begin
         mp = mptr;
         for (int i = 0; i < int'(draw_cnt); i++) begin
            if (mp == NC) begin
               ufp = 1'b1;
               break;
            end
            exp_q.push_back((int'(draw_pl) << 6) | int'(deck[mp]));
            mp++;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_log();
      log_card.delete();
      log_pl.delete();
      log_dc.delete();
      uf_seen = 0;
   endtask

   task automatic do_draw(int cnt, int pl);
      draw_cnt = 3'(cnt);
      draw_pl  = 2'(pl);
      draw_req = 1'b1;
      tick();
      draw_req = 1'b0;
   endtask

   task automatic wait_idle(int maxc, bit tog);
      bit [3:0] pat = 4'b1001;
      bit done = 1'b0;
      for (int c = 0; c < maxc; c++) begin
         card_ready = tog ? pat[c % 4] : 1'b1;
         tick();
         if (!busy) begin
            done = 1'b1;
            break;
         end
      end
      card_ready = 1'b1;
      if (!done) begin
         n_checks++;
         n_fail++;
         $display("FAIL wait_idle: busy still 1 after %0d cycles", maxc);
      end
   endtask

   initial begin
      for (int n = 0; n < NC; n++) deck[n] = 6'(n % 64);

      // Reset, then a deal request with no deck loaded.
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
      chk("rst_empty", int'(empty), 1);
      chk("rst_remaining", int'(remaining), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_valid", int'(card_valid), 0);
      deal_start = 1'b1;
      tick();
      deal_start = 1'b0;
      repeat (3) tick();
      chk("nodeck_busy", int'(busy), 0);
      chk("nodeck_valid", int'(card_valid), 0);

      // Load and run the opening deal.
      deck_valid = 1'b1;
      tick();
      deck_valid = 1'b0;
      chk("load_remaining", int'(remaining), 108);
      clear_log();
      deal_start = 1'b1;
      tick();
      deal_start = 1'b0;
      wait_idle(60, 1'b0);
      chk("deal_count", log_card.size(), 29);
      chk("deal_card0", log_card[0], 0);
      chk("deal_pl5", log_pl[5], 1);
      chk("deal_pl27", log_pl[27], 3);
      chk("deal_card27", log_card[27], 27);
      chk("flip_card", log_card[28], 28);
      chk("flip_disc", log_dc[28], 1);
      chk("flip_pl", log_pl[28], 0);
      chk("deal_disc0", log_dc[0], 0);
      chk("deal_remaining", int'(remaining), 79);
      chk("deal_busy", int'(busy), 0);

      // Draw four with stalling downstream.
      clear_log();
      do_draw(4, 2);
      wait_idle(40, 1'b1);
      chk("draw_count", log_card.size(), 4);
      chk("draw_card0", log_card[0], 29);
      chk("draw_card3", log_card[3], 32);
      chk("draw_pl", log_pl[3], 2);
      chk("draw_remaining", int'(remaining), 75);

      // Drain to two cards, then over-draw.
      for (int d = 0; d < 10; d++) begin
         do_draw(7, d % 4);
         wait_idle(20, 1'b0);
      end
      do_draw(3, 1);
      wait_idle(20, 1'b0);
      chk("drain_remaining", int'(remaining), 2);
      clear_log();
      do_draw(4, 3);
      wait_idle(20, 1'b0);
      chk("uf_count", log_card.size(), 2);
      chk("uf_last", log_card[1], 43);
      chk("uf_pulses", uf_seen, 1);
      chk("uf_empty", int'(empty), 1);
      chk("uf_busy", int'(busy), 0);

      // Coincident events in IDLE: only the reload takes effect.
      clear_log();
      deck_valid = 1'b1;
      deal_start = 1'b1;
      draw_cnt   = 3'd2;
      draw_req   = 1'b1;
      tick();
      deck_valid = 1'b0;
      deal_start = 1'b0;
      draw_req   = 1'b0;
      chk("co_remaining", int'(remaining), 108);
      chk("co_busy", int'(busy), 0);
      repeat (3) tick();
      chk("co_busy_later", int'(busy), 0);
      chk("co_count", log_card.size(), 0);

      // Reset in the middle of the deal.
      deal_start = 1'b1;
      tick();
      deal_start = 1'b0;
      repeat (5) tick();
      chk("pre_rst_valid", int'(card_valid), 1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", int'(card_valid), 0);
      chk("mid_rst_busy", int'(busy), 0);
      chk("mid_rst_card", int'(card), 0);
      chk("mid_rst_remaining", int'(remaining), 0);
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      chk("post_rst_empty", int'(empty), 1);
      clear_log();
      do_draw(3, 1);
      repeat (4) tick();
      chk("noreload_count", log_card.size(), 0);
      chk("noreload_uf", uf_seen, 1);
      chk("noreload_busy", int'(busy), 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/card_dealer.md
Name: card_dealer

Overview:
- Consumer end of the deck interface: takes the 108-entry shuffled deck and hands out cards one at a time from the top, using a valid/ready handshake.
- Runs the opening deal: HAND_SIZE cards to each player, round-robin, then flips one start card to the discard pile.
- After the deal, serves burst draw requests (1, 2 or 4 cards) for a named player.
- Tracks remaining cards and flags deck exhaustion so game control can trigger a reshuffle.

Parameters:
- N_CARDS, 108, deck depth; card encoding {color[1:0], value[3:0]}.
- N_PLAYERS, 4, players dealt round-robin (2..4).
- HAND_SIZE, 7, opening cards per player.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_deck  in  6 x N_CARDS (unpacked array)  shuffled deck; index 0 is the top card
- i_deck_valid  in  1  one-cycle pulse: i_deck is final; load it
- i_deal_start  in  1  one-cycle pulse: begin the opening deal
- i_draw_req  in  1  one-cycle pulse: draw request
- i_draw_cnt  in  3  number of cards to draw (1..7; 0 is ignored)
- i_draw_player  in  2  target player for the draw
- i_card_ready  in  1  downstream accepts o_card
- o_card_valid  out  1  o_card is valid
- o_card  out  6  card being dealt
- o_card_player  out  2  destination player
- o_card_discard  out  1  card goes to the discard pile (start flip)
- o_busy  out  1  dealer is not in IDLE
- o_empty  out  1  pointer == N_CARDS
- o_remaining  out  7  N_CARDS - pointer
- o_underflow  out  1  one-cycle pulse: draw cut short because the deck ran out

Behaviour:
- Reset values:
  - ptr = N_CARDS, so o_empty=1 and o_remaining=0.
  - State = IDLE.
  - All other outputs 0.
- Deck interface:
  - i_deck is read combinationally at index ptr.
  - Upstream holds i_deck stable from i_deck_valid until the next i_deck_valid.
- Card handshake:
  - A transfer occurs on a cycle where o_card_valid && i_card_ready.
  - o_card, o_card_player and o_card_discard stay stable while valid && !ready.
  - ptr increments by 1 per transfer.
  - o_card_valid never deasserts without a transfer, except on underflow or reset.
- States: IDLE, DEAL, FLIP, DRAW.
- IDLE:
  - i_deck_valid: ptr <= 0 next cycle; o_empty clears.
  - i_deal_start, if !o_empty: go to DEAL; deal counter k=0.
  - i_draw_req with i_draw_cnt != 0: latch cnt and player; go to DRAW.
  - Priority when events coincide: i_deck_valid > i_deal_start > i_draw_req. Lower-priority events in the same cycle are dropped.
  - i_deck_valid, i_deal_start and i_draw_req are ignored outside IDLE.
- DEAL:
  - o_card_valid=1; o_card_player = k mod N_PLAYERS.
  - k increments on each transfer.
  - After transfer k = N_PLAYERS*HAND_SIZE-1, go to FLIP.
- FLIP:
  - One card with o_card_discard=1 and o_card_player=0.
  - Go to IDLE after its transfer.
- DRAW:
  - Issue the latched cnt cards to the latched player, then go to IDLE.
- Latency: o_card_valid rises the cycle after the accepting IDLE cycle. With ready held high, the dealer produces 1 card per cycle.
- Exhaustion:
  - Entering DEAL, FLIP or DRAW with ptr == N_CARDS (including after the last transfer of a burst that still owes cards):
    - o_card_valid=0;
    - o_underflow pulses for 1 cycle;
    - remaining owed cards are dropped;
    - return to IDLE.
  - A burst that ends exactly at ptr=N_CARDS completes normally, with no underflow.
  - o_empty updates the cycle after the last transfer.
- o_busy = (state != IDLE).
- o_remaining: combinational from ptr; 7-bit unsigned.
- Asynchronous reset mid-burst: state returns to IDLE immediately and the in-flight card is lost. A new i_deck_valid is required before dealing again.

Test Plan:
- Reset, then i_deal_start without loading a deck -> no o_card_valid, o_busy stays 0, o_empty=1, o_remaining=0.
- Load deck (i_deck[n]=n mod 64), pulse i_deal_start, hold ready=1 -> 28 transfers with players 0,1,2,3,0,... and cards 0..27. Then 1 flip with card 28 and o_card_discard=1. Afterwards o_remaining=79, o_busy=0.
- After the deal, draw cnt=4 to player 2 with ready toggling 1,0,0,1,... -> exactly 4 transfers (cards 29..32, player 2). o_card is held stable during the ready=0 stalls; o_remaining=75.
- Drain the deck with draws until o_remaining=2, then draw cnt=4 -> 2 transfers, o_underflow pulses once, o_empty=1, back in IDLE.
- In IDLE, assert i_deck_valid, i_deal_start and i_draw_req in the same cycle -> deck reloads (ptr=0, o_remaining=108). The deal and draw are dropped; o_busy stays 0.
- Deassert i_rst_n mid-DEAL with valid=1 -> outputs 0 immediately; o_empty=1 after release. A draw_req before reload causes no transfers.
